// File: rtl/iob_pfsm_loader_pkg.sv
// Shared types and sizing helpers for the PFSM LUT loader.
// Pure declarations; no logic, no latency.
// Nothing here carries flow control.
package iob_pfsm_loader_pkg;

  // Sequencer states, in the order a load walks through them.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SRST_ON  = 3'd1,
    ST_GET      = 3'd2,
    ST_SEL      = 3'd3,
    ST_MEM      = 3'd4,
    ST_SRST_OFF = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  function automatic int CEIL_DIV(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Bus words needed to carry one {next_state, outputs} LUT entry.
  function automatic int calc_n_words(input int state_w, input int output_w, input int data_w);
    return CEIL_DIV(state_w + output_w, data_w);
  endfunction

  // One LUT entry per (input, state) combination.
  function automatic int calc_n_entries(input int input_w, input int state_w);
    return 1 << (input_w + state_w);
  endfunction

endpackage

// File: rtl/iob_pfsm_loader_wr.sv
// Single-write IOb master: captures one request and holds it on the bus.
// Request appears on the bus the cycle after req; ack is combinational on completion.
// Holds avalid/addr/wdata until the slave is ready; req is ignored while a write is pending.
module iob_pfsm_loader_wr #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic                req,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  output logic                avalid,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                ready,
  output logic                ack
);

  // Launch a write when idle, drop it on the handshake cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      avalid <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
    end else if (cke_i) begin
      if (!avalid) begin
        if (req) begin
          avalid <= 1'b1;
          addr   <= req_addr;
          wdata  <= req_data;
        end
      end else if (ready) begin
        avalid <= 1'b0;
      end
    end
  end

  // Completion is only real when the clock is enabled, so the caller's state advances with it.
  assign ack   = avalid & ready & cke_i;
  assign wstrb = {(DATA_W/8){avalid}};

endmodule

// File: rtl/iob_pfsm_loader.sv
// Sequences the IOb writes that program a PFSM LUT from a stream of entries.
// Each write occupies the bus from the cycle after its state is entered until the slave handshakes.
// entry_ready_o only in GET; a stalled slave stalls the whole load with bus outputs held.
module iob_pfsm_loader
  import iob_pfsm_loader_pkg::*;
#(
  parameter int DATA_W           = 32,
  parameter int ADDR_W           = 12,
  parameter int STATE_W          = 2,
  parameter int INPUT_W          = 1,
  parameter int OUTPUT_W         = 1,
  parameter int SOFTRESET_ADDR   = 0,
  parameter int WORD_SELECT_ADDR = 4,
  parameter int MEMORY_ADDR      = 64
) (
  input  logic                        clk_i,
  input  logic                        cke_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [STATE_W+OUTPUT_W-1:0] entry_i,
  input  logic                        entry_valid_i,
  output logic                        entry_ready_o,
  output logic                        iob_avalid_o,
  output logic [ADDR_W-1:0]           iob_addr_o,
  output logic [DATA_W-1:0]           iob_wdata_o,
  output logic [DATA_W/8-1:0]         iob_wstrb_o,
  input  logic                        iob_ready_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic [INPUT_W+STATE_W:0]    entry_cnt_o
);

  localparam int LUT_DATA_W = STATE_W + OUTPUT_W;
  localparam int N_BYTES    = CEIL_DIV(DATA_W, 8);
  localparam int N_WORDS    = calc_n_words(STATE_W, OUTPUT_W, DATA_W);
  localparam int N_ENTRIES  = calc_n_entries(INPUT_W, STATE_W);
  localparam int CNT_W      = INPUT_W + STATE_W + 1;
  localparam int W_W        = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int PAD_W      = N_WORDS * DATA_W;
  localparam int ADDR_SHIFT = $clog2(N_BYTES);

  localparam logic [W_W-1:0]   W_LAST   = W_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ENTRIES - 1);

  state_t                  state, state_nxt;
  logic [LUT_DATA_W-1:0]   entry_buf;
  logic [PAD_W-1:0]        buf_pad;
  logic [W_W-1:0]          w;
  logic [CNT_W-1:0]        entry_cnt;
  logic                    req, ack, avalid;
  logic [ADDR_W-1:0]       req_addr, mem_addr;
  logic [DATA_W-1:0]       req_data;

  // Entries narrower than the bus word set are zero-padded at the top.
  assign buf_pad  = PAD_W'(entry_buf);
  assign mem_addr = ADDR_W'(MEMORY_ADDR) + (ADDR_W'(entry_cnt) << ADDR_SHIFT);

  // State register plus the entry buffer, word counter and entry counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      entry_buf <= '0;
      w         <= '0;
      entry_cnt <= '0;
    end else if (cke_i) begin
      state <= state_nxt;
      if (state == ST_IDLE && start_i) begin
        entry_buf <= '0;
        entry_cnt <= '0;
      end
      if (state == ST_GET && entry_valid_i) begin
        entry_buf <= entry_i;
        w         <= '0;
      end
      if (state == ST_MEM && ack) begin
        if (w != W_LAST) w <= w + W_W'(1);
        else             entry_cnt <= entry_cnt + CNT_W'(1);
      end
    end
  end

  // Next state and the write request for the current state.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    case (state)
      ST_IDLE: if (start_i) state_nxt = ST_SRST_ON;
      ST_SRST_ON: begin
        req      = !avalid;
        req_addr = ADDR_W'(SOFTRESET_ADDR);
        req_data = DATA_W'(1);
        if (ack) state_nxt = ST_GET;
      end
      ST_GET: if (entry_valid_i) state_nxt = ST_SEL;
      ST_SEL: begin
        req      = !avalid;
        req_addr = ADDR_W'(WORD_SELECT_ADDR);
        req_data = DATA_W'(w);
        if (ack) state_nxt = ST_MEM;
      end
      ST_MEM: begin
        req      = !avalid;
        req_addr = mem_addr;
        req_data = buf_pad[w*DATA_W +: DATA_W];
        if (ack) begin
          if (w != W_LAST)              state_nxt = ST_SEL;
          else if (entry_cnt == CNT_LAST) state_nxt = ST_SRST_OFF;
          else                          state_nxt = ST_GET;
        end
      end
      ST_SRST_OFF: begin
        req      = !avalid;
        req_addr = ADDR_W'(SOFTRESET_ADDR);
        req_data = '0;
        if (ack) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  iob_pfsm_loader_wr #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wr (
    .clk_i    (clk_i),
    .cke_i    (cke_i),
    .rst_i    (rst_i),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .avalid   (avalid),
    .addr     (iob_addr_o),
    .wdata    (iob_wdata_o),
    .wstrb    (iob_wstrb_o),
    .ready    (iob_ready_i),
    .ack      (ack)
  );

  assign iob_avalid_o  = avalid;
  assign entry_ready_o = (state == ST_GET) & cke_i;
  assign busy_o        = (state != ST_IDLE);
  assign done_o        = (state == ST_DONE);
  assign entry_cnt_o   = entry_cnt;

endmodule

// File: tb/tb_iob_pfsm_loader.sv
// Scoreboard bench for the PFSM LUT loader: two configurations, randomized entries,
// slave stalls, entry gaps, redundant starts, mid-load reset and clock-enable pauses.
module tb_iob_pfsm_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cke;

  // Configuration A: default parameters (3-bit entries, 8 entries, 32-bit bus)
  logic        a_start, a_entry_vld, a_entry_rdy, a_avalid, a_ready, a_busy, a_done;
  logic [2:0]  a_entry;
  logic [11:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic [3:0]  a_cnt;

  // Configuration B: 11-bit entries split over two 8-bit bus words, 16 entries
  logic        b_start, b_entry_vld, b_entry_rdy, b_avalid, b_ready, b_busy, b_done;
  logic [10:0] b_entry;
  logic [11:0] b_addr;
  logic [7:0]  b_wdata;
  logic [0:0]  b_wstrb;
  logic [4:0]  b_cnt;

  iob_pfsm_loader dut_a (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(a_start),
    .entry_i(a_entry), .entry_valid_i(a_entry_vld), .entry_ready_o(a_entry_rdy),
    .iob_avalid_o(a_avalid), .iob_addr_o(a_addr), .iob_wdata_o(a_wdata),
    .iob_wstrb_o(a_wstrb), .iob_ready_i(a_ready), .busy_o(a_busy),
    .done_o(a_done), .entry_cnt_o(a_cnt)
  );

  iob_pfsm_loader #(.DATA_W(8), .STATE_W(3), .INPUT_W(1), .OUTPUT_W(8)) dut_b (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .start_i(b_start),
    .entry_i(b_entry), .entry_valid_i(b_entry_vld), .entry_ready_o(b_entry_rdy),
    .iob_avalid_o(b_avalid), .iob_addr_o(b_addr), .iob_wdata_o(b_wdata),
    .iob_wstrb_o(b_wstrb), .iob_ready_i(b_ready), .busy_o(b_busy),
    .done_o(b_done), .entry_cnt_o(b_cnt)
  );

  int checks = 0, failures = 0;
  logic [43:0] a_exp[$], b_exp[$];   // {addr, data} of each expected write, in order
  int a_stall = 0, a_hold = 0;
  int a_dones = 0, b_dones = 0, a_writes = 0, b_writes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Monitor A: every cycle a request is on the bus it must match the queue head.
  always @(negedge clk) if (!rst) begin
    if (a_avalid) begin
      if (a_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_write addr=%0h data=%0h", a_addr, a_wdata);
      end else begin
        chk("a_write", {20'd0, a_addr, a_wdata}, {20'd0, a_exp[0]});
        chk("a_wstrb", {60'd0, a_wstrb}, 64'hF);
        if (a_ready && cke) begin
          void'(a_exp.pop_front());
          a_writes++;
        end
      end
    end
    if (a_done && cke) a_dones++;
  end

  // Monitor B
  always @(negedge clk) if (!rst) begin
    if (b_avalid) begin
      if (b_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_write addr=%0h data=%0h", b_addr, b_wdata);
      end else begin
        chk("b_write", {20'd0, b_addr, 24'd0, b_wdata}, {20'd0, b_exp[0]});
        chk("b_wstrb", {63'd0, b_wstrb}, 64'h1);
        if (b_ready && cke) begin
          void'(b_exp.pop_front());
          b_writes++;
        end
      end
    end
    if (b_done && cke) b_dones++;
  end

  // Slave A: holds ready low for a_stall cycles of every request.
  initial begin
    a_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!a_avalid) begin
        a_hold  = 0;
        a_ready = (a_stall == 0);
      end else begin
        a_hold++;
        a_ready = (a_hold > a_stall);
      end
    end
  end

  // Reference: soft-reset on, then per entry (select word, write word) per bus word, soft-reset off.
  task automatic model_a(input logic [2:0] ents[8]);
    a_exp.push_back({12'd0, 32'd1});
    for (int k = 0; k < 8; k++) begin
      a_exp.push_back({12'd4, 32'd0});
      a_exp.push_back({12'(64 + 4*k), 32'(ents[k])});
    end
    a_exp.push_back({12'd0, 32'd0});
  endtask

  task automatic model_b(input logic [10:0] ents[16]);
    b_exp.push_back({12'd0, 32'd1});
    for (int k = 0; k < 16; k++)
      for (int wd = 0; wd < 2; wd++) begin
        b_exp.push_back({12'd4, 32'(wd)});
        b_exp.push_back({12'(64 + k), 32'((ents[k] >> (8*wd)) & 11'hFF)});
      end
    b_exp.push_back({12'd0, 32'd0});
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_a_start;
    a_start = 1'b1; tick; a_start = 1'b0;
  endtask

  task automatic present_a(input logic [2:0] e, input int gap);
    int n = 0;
    a_entry_vld = 1'b0;
    repeat (gap) tick;
    a_entry = e;
    a_entry_vld = 1'b1;
    forever begin
      @(negedge clk);
      if (a_entry_rdy && !rst) break;
      if (++n > 2000) begin timeout_fail("a_entry_accept"); break; end
    end
    tick;
    a_entry_vld = 1'b0;
  endtask

  task automatic present_b(input logic [10:0] e);
    int n = 0;
    b_entry = e;
    b_entry_vld = 1'b1;
    forever begin
      @(negedge clk);
      if (b_entry_rdy && !rst) break;
      if (++n > 2000) begin timeout_fail("b_entry_accept"); break; end
    end
    tick;
    b_entry_vld = 1'b0;
  endtask

  task automatic wait_a_done(input int d0);
    int n = 0;
    while (a_dones == d0 && n < 5000) begin tick; n++; end
    if (n >= 5000) timeout_fail("a_done");
    repeat (3) tick;
    chk("a_done_pulses", 64'(a_dones - d0), 64'd1);
    chk("a_queue_drained", 64'(a_exp.size()), 64'd0);
    chk("a_write_count", 64'(a_writes), 64'd18);
    chk("a_entry_cnt", 64'(a_cnt), 64'd8);
    chk("a_busy_after", 64'(a_busy), 64'd0);
  endtask

  // One full load on A; options for gaps, a redundant start, a cke pause and slave stalls.
  task automatic load_a(input bit seq, input int gap_max, input bit restart,
                        input bit cke_pause, input int stall);
    logic [2:0] ents[8];
    int d0, n;
    for (int k = 0; k < 8; k++) ents[k] = seq ? 3'(k) : 3'($urandom_range(0, 7));
    a_stall = stall;
    model_a(ents);
    a_writes = 0;
    d0 = a_dones;
    pulse_a_start;
    for (int k = 0; k < 8; k++) begin
      if (restart && k == 4) pulse_a_start;
      if (cke_pause && k == 2) begin
        n = 0;
        while (!a_avalid && n < 100) begin tick; n++; end
        if (n >= 100) timeout_fail("a_avalid_before_pause");
        cke = 1'b0;
        repeat (5) begin
          tick;
          chk("a_cke_hold_avalid", 64'(a_avalid), 64'd1);
          chk("a_cke_hold_busy", 64'(a_busy), 64'd1);
        end
        cke = 1'b1;
      end
      present_a(ents[k], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
    end
    wait_a_done(d0);
  endtask

  // Reset while entry 3's memory write is on the bus.
  task automatic reset_mid_load;
    logic [2:0] ents[8];
    int n = 0;
    for (int k = 0; k < 8; k++) ents[k] = 3'($urandom_range(0, 7));
    a_stall = 0;
    model_a(ents);
    pulse_a_start;
    for (int k = 0; k < 4; k++) present_a(ents[k], 0);
    while (!(a_avalid && a_addr == 12'd76) && n < 200) begin tick; n++; end
    if (n >= 200) timeout_fail("a_entry3_mem_write");
    chk("a_pre_reset_cnt", 64'(a_cnt), 64'd3);
    rst = 1'b1;
    a_exp.delete();
    tick;
    chk("a_rst_avalid", 64'(a_avalid), 64'd0);
    chk("a_rst_busy", 64'(a_busy), 64'd0);
    chk("a_rst_cnt", 64'(a_cnt), 64'd0);
    chk("a_rst_wstrb", 64'(a_wstrb), 64'd0);
    rst = 1'b0;
    tick;
  endtask

  task automatic load_b;
    logic [10:0] ents[16];
    int d0, n = 0;
    ents[0] = 11'h5A3;
    for (int k = 1; k < 16; k++) ents[k] = 11'($urandom_range(0, 2047));
    model_b(ents);
    b_writes = 0;
    d0 = b_dones;
    b_start = 1'b1; tick; b_start = 1'b0;
    for (int k = 0; k < 16; k++) present_b(ents[k]);
    while (b_dones == d0 && n < 5000) begin tick; n++; end
    if (n >= 5000) timeout_fail("b_done");
    repeat (3) tick;
    chk("b_done_pulses", 64'(b_dones - d0), 64'd1);
    chk("b_queue_drained", 64'(b_exp.size()), 64'd0);
    chk("b_write_count", 64'(b_writes), 64'd66);
    chk("b_entry_cnt", 64'(b_cnt), 64'd16);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cke = 1'b1;
    a_start = 1'b0; a_entry = '0; a_entry_vld = 1'b0;
    b_start = 1'b0; b_entry = '0; b_entry_vld = 1'b0; b_ready = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    tick;
    chk("rst_a_avalid", 64'(a_avalid), 64'd0);
    chk("rst_a_busy", 64'(a_busy), 64'd0);
    chk("rst_a_done", 64'(a_done), 64'd0);
    chk("rst_a_cnt", 64'(a_cnt), 64'd0);
    chk("rst_a_entry_rdy", 64'(a_entry_rdy), 64'd0);
    chk("rst_a_bus", {20'd0, a_addr, a_wdata}, 64'd0);
    chk("rst_a_wstrb", 64'(a_wstrb), 64'd0);
    chk("rst_b_avalid", 64'(b_avalid), 64'd0);
    chk("rst_b_cnt", 64'(b_cnt), 64'd0);

    load_a(1'b1, 0, 1'b0, 1'b0, 0);   // entries 0..7, slave always ready
    load_a(1'b0, 0, 1'b0, 1'b0, 3);   // slave stalls 3 cycles per write
    load_a(1'b0, 4, 1'b1, 1'b0, 0);   // entry gaps and a redundant start
    reset_mid_load;
    load_a(1'b1, 0, 1'b0, 1'b0, 0);   // full load after the aborted one
    load_a(1'b0, 2, 1'b0, 1'b1, 1);   // clock-enable pause with a request pending
    load_b;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_pfsm_loader.md
Name: iob_pfsm_loader

Overview:
- Sequencer that programs a PFSM's LUT through its IOb-native slave register interface.
- Accepts a stream of LUT entries (next_state, output pairs) and sequences the required bus writes: soft-reset assert, word select, memory window write per bus word, then soft-reset release.
- Sits between a boot ROM/DMA/config stream and one PFSM instance, so firmware need not hand-write LUT images.

Parameters:
- DATA_W, 32, IOb data width; must match the target PFSM.
- ADDR_W, 12, IOb address width.
- STATE_W, 2, PFSM state width.
- INPUT_W, 1, PFSM input width.
- OUTPUT_W, 1, PFSM output width.
- SOFTRESET_ADDR, 0, byte address of the PFSM SOFTRESET register.
- WORD_SELECT_ADDR, 4, byte address of the PFSM MEM_WORD_SELECT register.
- MEMORY_ADDR, 64, byte base address of the PFSM LUT memory window.
- Derived (localparam): LUT_DATA_W = STATE_W+OUTPUT_W.
- Derived (localparam): N_BYTES = ceil(DATA_W/8).
- Derived (localparam): N_WORDS = ceil(LUT_DATA_W/DATA_W).
- Derived (localparam): N_ENTRIES = 2^(INPUT_W+STATE_W).

Ports:
- clk_i  in  1  clock.
- cke_i  in  1  clock enable; all state holds when low.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  begin a load; sampled only in IDLE.
- entry_i  in  LUT_DATA_W  LUT entry, laid out as {next_state, outputs}.
- entry_valid_i  in  1  entry_i valid.
- entry_ready_o  out  1  loader accepts entry_i this cycle.
- iob_avalid_o  out  1  IOb request valid.
- iob_addr_o  out  ADDR_W  IOb byte address.
- iob_wdata_o  out  DATA_W  IOb write data.
- iob_wstrb_o  out  DATA_W/8  IOb write strobe; all ones whenever avalid is high, zero otherwise.
- iob_ready_i  in  1  IOb slave ready.
- busy_o  out  1  load in progress.
- done_o  out  1  one-cycle pulse when the load completes.
- entry_cnt_o  out  INPUT_W+STATE_W+1  number of entries written so far.

Behaviour:
- Reset values:
  - all outputs 0; entry_cnt_o=0.
  - FSM in IDLE.
- Clock and reset: one clock, clk_i. Reset is synchronous, active-high, on rst_i. All registers update only when cke_i=1, except that rst_i has priority.
- Bus transaction rule:
  - iob_avalid_o rises with addr/wdata/wstrb stable.
  - All of them hold until the cycle where iob_avalid_o & iob_ready_i; that cycle completes the write.
  - The next request may start on the following cycle at the earliest.
  - The loader issues no reads; rvalid/rdata are not ports.
- FSM states and transitions:
  - IDLE: start_i=1 -> SRST_ON.
  - SRST_ON: write 1 to SOFTRESET_ADDR; on completion -> GET.
  - GET: entry_ready_o=1. On entry_valid_i, latch entry_i into a LUT_DATA_W buffer, set word counter w=0 -> SEL.
  - SEL: write w to WORD_SELECT_ADDR -> MEM.
  - MEM: write to address MEMORY_ADDR + (entry_cnt << clog2(N_BYTES)), data = buffer[w*DATA_W +: DATA_W], zero-padded above LUT_DATA_W.
    - If w<N_WORDS-1: w++ -> SEL.
    - Else: entry_cnt++; if entry_cnt reached N_ENTRIES -> SRST_OFF, else -> GET.
  - SRST_OFF: write 0 to SOFTRESET_ADDR -> DONE.
  - DONE: done_o=1 for one cycle -> IDLE. entry_cnt_o keeps its final value until the next start.
- entry_cnt_o and the buffer clear on entering SRST_ON.
- busy_o=1 in every state except IDLE.
- Word-select writes are issued for every bus word, including when N_WORDS=1. Total writes per load = 2 + 2*N_WORDS*N_ENTRIES.
- entry_ready_o is high only in GET; it never combinationally depends on entry_valid_i.
- start_i is ignored while busy_o=1.
- entry_valid_i outside GET is ignored and the entry is not consumed.
- Address arithmetic is done at ADDR_W width and wraps modulo 2^ADDR_W. Misconfiguration is the integrator's responsibility.
- iob_ready_i held low stalls indefinitely; there is no timeout.
- rst_i mid-load: next cycle is IDLE, iob_avalid_o=0, counters cleared.
  - Any in-flight request is dropped.
  - The PFSM may be left in soft reset with a partial LUT; recovery requires a new start_i.
- cke_i=0 mid-transaction: iob_avalid_o and all bus outputs hold their values.

Decomposition:
- Package iob_pfsm_loader_pkg holds:
  - FSM state encoding constants (IDLE, SRST_ON, GET, SEL, MEM, SRST_OFF, DONE);
  - the CEIL_DIV helper;
  - the N_WORDS/N_ENTRIES derivations.
- One sub-module, iob_pfsm_loader_wr: a single-write IOb master.
  - Inputs: req/addr/data.
  - Outputs: avalid/addr/wdata/wstrb and a one-cycle ack on completion.
  - Used by every write state.

Test Plan:
- Default params (DATA_W=32, STATE_W=2, INPUT_W=1, OUTPUT_W=1): start, 8 entries 0..7, slave ready always 1 -> exactly 18 writes in order: SOFTRESET=1, then (WS=0, MEM@64+4k=k) for k=0..7, then SOFTRESET=0; done_o pulses once; entry_cnt_o=8.
- DATA_W=8, STATE_W=3, OUTPUT_W=8, INPUT_W=1 (11-bit entries, N_WORDS=2, 16 entries): entry 0x5A3 -> WS=0, MEM=0xA3, WS=1, MEM=0x05 at address 64+k; 66 writes total.
- Slave stalls with iob_ready_i low 3 cycles on each write -> avalid/addr/wdata stable throughout every stall; order unchanged; done_o still single pulse.
- entry_valid_i toggles (gaps of 0-4 cycles), start_i pulsed again mid-load -> no entry lost or duplicated; the second start has no effect.
- rst_i asserted during a MEM write of entry 3 -> next cycle avalid=0, busy_o=0, entry_cnt_o=0; a fresh start_i then completes a full 18-write load.
- cke_i low for 5 cycles while avalid=1 -> outputs frozen; after cke returns, the load completes with correct count.
